// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: 8x32 register file feeding an AND/OR/ADD/SUB ALU.
// Commands arrive over valid/ready and results leave over valid/ready with NZCV flags.
module alu_exec_unit #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             cmd_use_imm,
    input  logic [IMM_W-1:0] cmd_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [3:0]       res_flags,
    input  logic [AW-1:0]    dbg_addr,
    output logic [31:0]      dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [31:0]      regs_q [NREGS];
    logic [1:0]       op_q;
    logic [AW-1:0]    rd_q, rs1_q, rs2_q;
    logic             useImm_q;
    logic [IMM_W-1:0] imm_q;
    logic [31:0]      opA_q, opB_q;
    logic [31:0]      resData_q;
    logic [3:0]       resFlags_q;

    logic [31:0] immExt;
    logic [31:0] rs1Val, rs2Val;
    logic [32:0] addSum, subSum;
    logic [31:0] aluResult;
    logic        aluCarry, aluOverflow;

    assign immExt = {{(32-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign rs1Val = (rs1_q == '0) ? 32'd0 : regs_q[rs1_q];
    assign rs2Val = (rs2_q == '0) ? 32'd0 : regs_q[rs2_q];
    assign dbg_data = (dbg_addr == '0) ? 32'd0 : regs_q[dbg_addr];

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == WB);
    assign res_data  = resData_q;
    assign res_flags = resFlags_q;

    // Subtraction is A + ~B + 1, so C=1 means "no borrow".
    assign addSum = {1'b0, opA_q} + {1'b0, opB_q};
    assign subSum = {1'b0, opA_q} + {1'b0, ~opB_q} + 33'd1;

    always_comb begin
        aluResult   = opA_q & opB_q;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        case (op_q)
            2'b00: aluResult = opA_q & opB_q;
            2'b01: aluResult = opA_q | opB_q;
            2'b10: begin
                aluResult   = addSum[31:0];
                aluCarry    = addSum[32];
                aluOverflow = (opA_q[31] == opB_q[31]) && (aluResult[31] != opA_q[31]);
            end
            default: begin
                aluResult   = subSum[31:0];
                aluCarry    = subSum[32];
                aluOverflow = (opA_q[31] != opB_q[31]) && (aluResult[31] != opA_q[31]);
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            useImm_q   <= 1'b0;
            imm_q      <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            resData_q  <= '0;
            resFlags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                op_q     <= cmd_op;
                rd_q     <= cmd_rd;
                rs1_q    <= cmd_rs1;
                rs2_q    <= cmd_rs2;
                useImm_q <= cmd_use_imm;
                imm_q    <= cmd_imm;
            end
            if (state_q == READ) begin
                opA_q <= rs1Val;
                opB_q <= useImm_q ? immExt : rs2Val;
            end
            if (state_q == EXEC) begin
                resData_q  <= aluResult;
                resFlags_q <= {aluResult[31], (aluResult == 32'd0), aluCarry, aluOverflow};
            end
        end
    end

    // The write lands on the edge that enters WB, so it is visible throughout WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (state_q == EXEC && rd_q != '0) begin
            regs_q[rd_q] <= aluResult;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed results, flags, latency,
// backpressure hold and reset abandonment.
module tb_alu_exec_unit;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    task automatic driveCmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic useImm, input logic [15:0] imm);
        cmd_op      = op;
        cmd_rd      = rd;
        cmd_rs1     = rs1;
        cmd_rs2     = rs2;
        cmd_use_imm = useImm;
        cmd_imm     = imm;
        cmd_valid   = 1'b1;
    endtask

    // Waits at falling edges for res_valid; returns the number of cycles waited.
    task automatic waitResult(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 20);
    endtask

    // One full command: accept, latency, result/flags, handshake, return to idle.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2, input logic useImm,
                                 input logic [15:0] imm, input logic [31:0] expData,
                                 input logic [3:0] expFlags);
        int n;
        @(negedge clk);
        driveCmd(op, rd, rs1, rs2, useImm, imm);
        res_ready = 1'b1;
        checkOutput({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waitResult(n);
        checkOutput({tag, "_latency"}, n, 32'd3);
        checkOutput({tag, "_data"}, res_data, expData);
        checkOutput({tag, "_flags"}, {28'd0, res_flags}, {28'd0, expFlags});
        @(negedge clk);
        checkOutput({tag, "_done"}, {30'd0, res_valid, cmd_ready}, 32'd1);
        res_ready = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [2:0] addr, input logic [31:0] expected);
        dbg_addr = addr;
        #1 checkOutput(tag, dbg_data, expected);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        driveCmd(OP_AND, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
        cmd_valid = 1'b0;
        dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 1; i < 8; i++) checkReg($sformatf("rst_r%0d", i), 3'(i), 32'd0);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_data", res_data, 32'd0);
        checkOutput("rst_flags", {28'd0, res_flags}, 32'd0);

        applyStimulus("r1_imm",   OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 32'h0000_7FFF, 4'b0000);
        applyStimulus("r2_dbl",   OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, 32'h0000_FFFE, 4'b0000);
        checkReg("r2_wb", 3'd2, 32'h0000_FFFE);
        applyStimulus("r3_neg1",  OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 4'b1000);
        applyStimulus("r4_wrap",  OP_ADD, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0001, 32'h0000_0000, 4'b0110);
        applyStimulus("r5_sext",  OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'h8000, 32'hFFFF_8000, 4'b1000);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            e = 32'hFFFF_8000 << (i + 1);
            applyStimulus($sformatf("r5_shl%0d", i), OP_ADD, 3'd5, 3'd5, 3'd5, 1'b0, 16'h0, e,
                          {e[31], 1'b0, 1'b1, 1'b0});
        end
        checkReg("r5_min", 3'd5, 32'h8000_0000);
        applyStimulus("r5_sub",   OP_SUB, 3'd5, 3'd5, 3'd0, 1'b1, 16'h0001, 32'h7FFF_FFFF, 4'b0011);
        applyStimulus("r6_ovf",   OP_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 16'h0001, 32'h8000_0000, 4'b1001);
        applyStimulus("r4_and",   OP_AND, 3'd4, 3'd3, 3'd3, 1'b0, 16'h0000, 32'hFFFF_FFFF, 4'b1000);
        applyStimulus("r4_or",    OP_OR,  3'd4, 3'd2, 3'd1, 1'b0, 16'h0000, 32'h0000_FFFF, 4'b0000);
        applyStimulus("r1_self",  OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, 32'h0000_8000, 4'b0000);
        applyStimulus("r0_drop",  OP_SUB, 3'd0, 3'd2, 3'd2, 1'b0, 16'h0000, 32'h0000_0000, 4'b0110);
        checkReg("r0_zero", 3'd0, 32'd0);
        checkReg("r6_wb", 3'd6, 32'h8000_0000);

        // Backpressure: result held, pending command refused until after handshake.
        @(negedge clk);
        driveCmd(OP_OR, 3'd3, 3'd0, 3'd0, 1'b1, 16'h1234);
        res_ready = 1'b0;
        @(posedge clk);
        #1 driveCmd(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0055);
        waitResult(n);
        checkOutput("hold_latency", n, 32'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold_valid%0d", i), {31'd0, res_valid}, 32'd1);
            checkOutput($sformatf("hold_data%0d", i), res_data, 32'h0000_1234);
            checkOutput($sformatf("hold_ready%0d", i), {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checkOutput("hs_idle", {30'd0, res_valid, cmd_ready}, 32'd1);
        checkOutput("hs_retain", res_data, 32'h0000_1234);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("next_accepted", {31'd0, cmd_ready}, 32'd0);
        waitResult(n);
        checkOutput("next_latency", n, 32'd2);
        checkOutput("next_data", res_data, 32'h0000_0055);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkReg("r3_hold", 3'd3, 32'h0000_1234);

        // Reset during EXEC abandons the command.
        @(negedge clk);
        driveCmd(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0005);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkReg("rst_r7", 3'd7, 32'd0);
        checkOutput("rst2_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst2_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst2_data", res_data, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
